// File: rtl/fifo_write_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// arbiter_pkg
// Shared constants and helpers for the fifo_write_arbiter slice.
//   clog2_min1() : ceiling log2, never less than 1 (pointer/index width)
//   DEF_PTR_W    : pointer width for the default writer count
// ---------------------------------------------------------------------------
package arbiter_pkg;

  localparam int NUM_WRITERS_DEF = 4;

  function automatic int clog2_min1(input int n);
    int w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

  localparam int DEF_PTR_W = clog2_min1(NUM_WRITERS_DEF);

endpackage

// File: rtl/fifo_write_arbiter_if.sv
// ---------------------------------------------------------------------------
// fifo_write_arbiter_if
// Writer/FIFO-side bundle of the write arbiter.
//   i_data       : concatenated writer words, writer k at [k*DATA_W +: DATA_W]
//   i_req        : per-writer request
//   o_busy       : per-writer busy (0 for one cycle = acknowledge)
//   i_fifo_ready : FIFO can accept one more write next cycle
//   o_we/o_data  : FIFO write strobe and word
// master = writers + FIFO, slave = arbiter.
// ---------------------------------------------------------------------------
interface fifo_write_arbiter_if #(
  parameter int NUM_WRITERS = 4,
  parameter int DATA_W      = 8
);
  logic [NUM_WRITERS*DATA_W-1:0] i_data;
  logic [NUM_WRITERS-1:0]        i_req;
  logic [NUM_WRITERS-1:0]        o_busy;
  logic                          i_fifo_ready;
  logic                          o_we;
  logic [DATA_W-1:0]             o_data;

  modport master (
    output i_data, i_req, i_fifo_ready,
    input  o_busy, o_we, o_data
  );

  modport slave (
    input  i_data, i_req, i_fifo_ready,
    output o_busy, o_we, o_data
  );
endinterface

// File: rtl/fifo_write_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Purely combinational round-robin picker: first eligible index found by
// searching upward from ptr_i+1, wrapping modulo NUM_WRITERS.
//   eligible_i  : eligible writers
//   ptr_i       : last winner (search starts just above it)
//   grant_oh_o  : one-hot winner
//   grant_idx_o : winner index
//   valid_o     : at least one writer eligible
// ---------------------------------------------------------------------------
module rr_pick
  import arbiter_pkg::*;
#(
  parameter int NUM_WRITERS = NUM_WRITERS_DEF,
  parameter int PTR_W       = DEF_PTR_W
) (
  input  logic [NUM_WRITERS-1:0] eligible_i,
  input  logic [PTR_W-1:0]       ptr_i,
  output logic [NUM_WRITERS-1:0] grant_oh_o,
  output logic [PTR_W-1:0]       grant_idx_o,
  output logic                   valid_o
);

  logic [PTR_W-1:0] idx_w;

  always_comb begin
    // NOTE: every output gets a default before the search so no path leaves
    // a value unassigned, which would otherwise infer a latch.
    grant_oh_o  = '0;
    grant_idx_o = '0;
    valid_o     = 1'b0;
    idx_w       = '0;
    for (int off = 1; off <= NUM_WRITERS; off++) begin
      idx_w = PTR_W'((int'(ptr_i) + off) % NUM_WRITERS);
      if (!valid_o && eligible_i[idx_w]) begin
        valid_o            = 1'b1;
        grant_idx_o        = idx_w;
        grant_oh_o[idx_w]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_write_arbiter.sv
// ---------------------------------------------------------------------------
// fifo_write_arbiter
// Merges N writer channels into one FIFO write port. One grant per cycle;
// the granted word is registered onto the FIFO bus and the writer is
// acknowledged by its busy line dropping for exactly one cycle.
//   i_clk     : clock
//   i_reset_n : asynchronous active-low reset
//   bus       : fifo_write_arbiter_if.slave (writer requests/data, busy,
//               FIFO ready, write strobe/data)
// Build option: ARBITER_FIXED_PRIO_EN -- drop the round-robin pointer, the
// lowest eligible index always wins.
// ---------------------------------------------------------------------------
module fifo_write_arbiter
  import arbiter_pkg::*;
#(
  parameter int NUM_WRITERS = 4,
  parameter int DATA_W      = 8
) (
  input logic                  i_clk,
  input logic                  i_reset_n,
  fifo_write_arbiter_if.slave  bus
);

  localparam int PTR_W = clog2_min1(NUM_WRITERS);

  logic [NUM_WRITERS-1:0] busy_q, busy_d;
  logic                   we_q, we_d;
  logic [DATA_W-1:0]      data_q, data_d;
  logic [NUM_WRITERS-1:0] eligible, grant_oh;
  logic [PTR_W-1:0]       pick_ptr, grant_idx;
  logic                   valid, grant;

  // A writer in its acknowledge cycle is excluded so its stale word is not
  // written twice; this also caps one writer at one grant per two cycles.
  assign eligible = bus.i_req & busy_q;
  assign grant    = valid & bus.i_fifo_ready;

`ifdef ARBITER_FIXED_PRIO_EN
  // Search always starts at index 0.
  assign pick_ptr = PTR_W'(NUM_WRITERS - 1);
`else
  logic [PTR_W-1:0] ptr_q, ptr_d;

  assign pick_ptr = ptr_q;
  assign ptr_d    = grant ? grant_idx : ptr_q;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) ptr_q <= PTR_W'(NUM_WRITERS - 1);
    else            ptr_q <= ptr_d;
  end
`endif

  rr_pick #(
    .NUM_WRITERS (NUM_WRITERS),
    .PTR_W       (PTR_W)
  ) u_pick (
    .eligible_i  (eligible),
    .ptr_i       (pick_ptr),
    .grant_oh_o  (grant_oh),
    .grant_idx_o (grant_idx),
    .valid_o     (valid)
  );

  always_comb begin
    busy_d = '1;
    we_d   = grant;
    data_d = data_q;  // word holds when nothing is written
    if (grant) begin
      busy_d = ~grant_oh;
      data_d = bus.i_data[int'(grant_idx)*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    // NOTE: state registers use non-blocking assignment so every flop samples
    // the pre-edge values regardless of statement order.
    if (!i_reset_n) begin
      busy_q <= '1;
      we_q   <= 1'b0;
      data_q <= '0;
    end else begin
      busy_q <= busy_d;
      we_q   <= we_d;
      data_q <= data_d;
    end
  end

  assign bus.o_busy = busy_q;
  assign bus.o_we   = we_q;
  assign bus.o_data = data_q;

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// ---------------------------------------------------------------------------
// tb_fifo_write_arbiter
// Self-checking bench for fifo_write_arbiter (4 writers, 8-bit words).
// Directed scenarios with literal expectations, then randomized writers and
// FIFO ready checked every cycle against a behavioural model.
// Honours ARBITER_FIXED_PRIO_EN the same way as the design.
// ---------------------------------------------------------------------------
module tb_fifo_write_arbiter;

  localparam int N = 4;
  localparam int W = 8;
`ifdef ARBITER_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fifo_write_arbiter_if #(.NUM_WRITERS(N), .DATA_W(W)) bus ();

  fifo_write_arbiter #(.NUM_WRITERS(N), .DATA_W(W)) dut (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .bus       (bus)
  );

  // Writer-side stimulus
  logic [W-1:0] wdata [N];
  logic [N-1:0] req;
  logic         ready;
  bit           cmp_en;

  always_comb begin
    bus.i_data = '0;
    for (int k = 0; k < N; k++) bus.i_data[k*W +: W] = wdata[k];
  end
  assign bus.i_req        = req;
  assign bus.i_fifo_ready = ready;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ------------------------------------------------------------------
  // Behavioural model: first eligible writer above the last winner.
  // ------------------------------------------------------------------
  function automatic int pick(input logic [N-1:0] elig, input int ptr);
    for (int off = 1; off <= N; off++) begin
      int idx = (ptr + off) % N;
      if (elig[idx]) return idx;
    end
    return -1;
  endfunction

  logic [N-1:0] m_busy;
  logic         m_we;
  logic [W-1:0] m_data;
  int           m_ptr;
  int           m_win;

  always_comb m_win = pick(req & m_busy, FIXED ? N - 1 : m_ptr);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= '1;
      m_we   <= 1'b0;
      m_data <= '0;
      m_ptr  <= N - 1;
    end else if (ready && m_win >= 0) begin
      m_busy <= ~(N'(1) << m_win);
      m_we   <= 1'b1;
      m_data <= wdata[m_win];
      m_ptr  <= m_win;
    end else begin
      m_busy <= '1;
      m_we   <= 1'b0;
    end
  end

  // Compare process: DUT vs model plus handshake invariants, every cycle.
  always @(negedge clk) begin
    if (cmp_en && rst_n) begin
      int lows;
      lows = N - $countones(bus.o_busy);
      check("model_busy", bus.o_busy, m_busy);
      check("model_we",   bus.o_we,   m_we);
      check("model_data", bus.o_data, m_data);
      check("inv_one_low", (lows <= 1), 1);
      check("inv_we_eq_low", bus.o_we, (lows == 1));
    end
  end

  task automatic pulse_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] exp_b;
    int           nwr;
    req    = '0;
    ready  = 1'b1;
    for (int k = 0; k < N; k++) wdata[k] = '0;
    cmp_en = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Reset state, held with no requests
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("rst_busy", bus.o_busy, 4'hF);
      check("rst_we",   bus.o_we,   1'b0);
      check("rst_data", bus.o_data, 8'h00);
    end

    // Single writer 2
    wdata[2] = 8'hA5;
    req      = 4'b0100;
    @(negedge clk);
    check("single_we",   bus.o_we,   1'b1);
    check("single_data", bus.o_data, 8'hA5);
    check("single_busy", bus.o_busy, 4'b1011);
    req[2] = 1'b0;
    @(negedge clk);
    check("single_busy_back", bus.o_busy, 4'hF);
    check("single_no_rewrite", bus.o_we, 1'b0);
    @(negedge clk);
    check("single_idle_data", bus.o_data, 8'hA5);

    // All-request fairness (fixed build: writers 0 and 3 alternate)
    pulse_reset();
    for (int k = 0; k < N; k++) wdata[k] = 8'h10 + W'(k);
    req = FIXED ? 4'b1001 : 4'hF;
    for (int i = 0; i < 8; i++) begin
      int who;
      @(negedge clk);
      who   = FIXED ? ((i % 2 == 0) ? 0 : 3) : (i % 4);
      exp_b = ~(N'(1) << who);
      check("fair_we",   bus.o_we,   1'b1);
      check("fair_data", bus.o_data, 8'h10 + W'(who));
      check("fair_busy", bus.o_busy, exp_b);
    end
    req = '0;
    repeat (2) @(negedge clk);

    // Back-pressure: ready low for four cycles
    pulse_reset();
    wdata[1] = 8'h21;
    wdata[3] = 8'h23;
    req      = 4'b1010;
    ready    = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("bp_blocked_we", bus.o_we, 1'b0);
    end
    ready = 1'b1;
    @(negedge clk);
    check("bp_first_data", bus.o_data, 8'h21);
    check("bp_first_busy", bus.o_busy, 4'b1101);
    req[1] = 1'b0;
    @(negedge clk);
    check("bp_second_data", bus.o_data, 8'h23);
    check("bp_second_busy", bus.o_busy, 4'b0111);
    req[3] = 1'b0;
    @(negedge clk);
    check("bp_drain_we", bus.o_we, 1'b0);

    // Reset in the cycle after a grant
    wdata[0] = 8'h5A;
    req      = 4'b0001;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_we",   bus.o_we,   1'b0);
    check("midrst_busy", bus.o_busy, 4'hF);
    check("midrst_data", bus.o_data, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    nwr   = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.o_we && bus.o_data == 8'h5A) nwr++;
      if (!bus.o_busy[0]) req[0] = 1'b0;
    end
    check("midrst_rewrites", nwr, 1);

    // Randomized writers and FIFO ready
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      for (int k = 0; k < N; k++) begin
        if (!bus.o_busy[k]) begin
          req[k]   = 1'($urandom_range(0, 1));
          wdata[k] = W'($urandom);
        end else if (!req[k] && $urandom_range(0, 2) == 0) begin
          req[k]   = 1'b1;
          wdata[k] = W'($urandom);
        end
      end
      ready = ($urandom_range(0, 3) != 0);
    end
    req = '0;
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
